pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path: holds the architectural PC register and loads the NextPC value produced by the next-PC logic.
- Fetches the 32-bit instruction at the current PC from instruction memory over a req/ack handshake.
- Presents the instruction to decode with a valid flag and waits for the core to retire it before advancing.
- Traps misaligned branch targets and counts completed fetches.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.
- TIMEOUT, 16, max cycles to wait for IMemAck before flagging FetchTimeout; valid range 1..65535.

Ports:
- CLK  in  1  sole clock, rising edge.
- resetl  in  1  asynchronous, active-low reset.
- NextPC  in  64  next PC from next-PC logic; sampled only on an accepted PCUpdate.
- PCUpdate  in  1  single-cycle pulse: current instruction retired, load NextPC.
- CurrentPC  out  64  architectural PC; feeds next-PC logic and IMemAddr.
- IMemReq  out  1  fetch request to instruction memory.
- IMemAddr  out  64  fetch address; equals CurrentPC.
- IMemAck  in  1  memory response strobe; data valid in the same cycle.
- IMemRdData  in  32  instruction word from memory.
- Instruction  out  32  registered instruction for decode.
- InstrValid  out  1  Instruction is valid for CurrentPC.
- Misaligned  out  1  sticky: NextPC[1:0] != 0 was presented on PCUpdate.
- FetchTimeout  out  1  sticky: ack not seen within TIMEOUT cycles.
- FetchCount  out  32  completed fetches; wraps at 2^32.

Behaviour:
- Reset (resetl=0, async, takes effect immediately, including mid-fetch):
  - State = FETCH; CurrentPC = RESET_PC.
  - IMemReq = 0 while reset is asserted. IMemReq is registered and rises on the first CLK edge after resetl deasserts.
  - Instruction = 0; InstrValid = 0; Misaligned = 0; FetchTimeout = 0; FetchCount = 0; wait counter = 0.
- State FETCH:
  - IMemReq = 1; IMemAddr = CurrentPC. The address is held stable while the request is outstanding.
  - On an edge with IMemAck = 1: Instruction <= IMemRdData, InstrValid <= 1, IMemReq <= 0, FetchCount += 1, wait counter cleared, go to VALID.
  - Ack-to-InstrValid latency is 1 cycle. Minimum fetch is 2 cycles (request edge, then ack edge).
  - Without ack, the wait counter increments each cycle. When it reaches TIMEOUT, FetchTimeout <= 1 (sticky). The request stays asserted and the counter saturates.
  - PCUpdate in FETCH is ignored; CurrentPC is unchanged.
- State VALID:
  - IMemReq = 0; Instruction and InstrValid are held stable.
  - On PCUpdate = 1 with NextPC[1:0] == 0: CurrentPC <= NextPC, InstrValid <= 0, IMemReq <= 1, go to FETCH.
  - On PCUpdate = 1 with NextPC[1:0] != 0: Misaligned <= 1, InstrValid <= 0, CurrentPC unchanged, go to HALT.
  - NextPC == CurrentPC (self-branch) is legal and refetches the same address.
- State HALT:
  - IMemReq = 0; InstrValid = 0; all inputs ignored. Exits only via reset.
- Stray inputs:
  - IMemAck outside FETCH is ignored. It has no effect on Instruction or FetchCount.
- Simultaneous events:
  - IMemAck and PCUpdate in the same FETCH cycle: the ack is taken and PCUpdate is dropped.
  - The core must only pulse PCUpdate while InstrValid = 1.
- Arithmetic:
  - The PC is unsigned 64-bit. NextPC is loaded verbatim, with no add in this block, so wrap-around is the producer's concern.
  - FetchCount wraps from 32'hFFFFFFFF to 0.

Test Plan:
- Reset release with RESET_PC=0, ack on 2nd request cycle with IMemRdData=32'h8B020020 -> IMemAddr=0; Instruction=32'h8B020020 and InstrValid=1 one cycle after ack; FetchCount=1.
- Sequential flow: from VALID at PC=0x10, PCUpdate with NextPC=0x14 -> CurrentPC=0x14 next edge, InstrValid=0, IMemReq=1; after ack, InstrValid=1 and FetchCount increments.
- Branch, then misaligned target: PCUpdate NextPC=0x40 -> refetch at 0x40. Then PCUpdate NextPC=0x46 -> Misaligned=1, HALT, CurrentPC stays 0x40, IMemReq stays 0 for 20 cycles despite acks and PCUpdates.
- Timeout with TIMEOUT=4: withhold ack for 6 cycles -> FetchTimeout=1 after 4 waiting cycles, IMemReq stays 1. Ack on cycle 7 -> instruction captured, FetchTimeout remains 1.
- Async reset mid-fetch: assert resetl=0 between clock edges while IMemReq=1 at PC=0x80 -> IMemReq, InstrValid and FetchCount are 0 immediately, before the next edge, and CurrentPC=RESET_PC. After release, the first request goes to RESET_PC.
- Stray and simultaneous inputs: IMemAck pulsed in VALID -> Instruction and FetchCount unchanged. PCUpdate coincident with IMemAck in FETCH -> ack captured, CurrentPC unchanged.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Purpose : architectural PC register plus instruction fetch over an IMemReq/IMemAck handshake.
// Latency : the instruction is registered one cycle after IMemAck; a fetch takes at least 2 cycles.
// Backpr. : waits without limit for IMemAck, and FetchTimeout flags the wait; holds Instruction until PCUpdate.
//
// Ports:
//   CLK, resetl                 clock (rising edge) and asynchronous active-low reset
//   NextPC, PCUpdate            next PC, and the retire pulse that loads it (honoured only in VALID)
//   CurrentPC, IMemAddr         architectural PC; the fetch address is always the PC
//   IMemReq, IMemAck, IMemRdData  instruction memory handshake
//   Instruction, InstrValid     registered instruction for decode
//   Misaligned, FetchTimeout    sticky error flags
//   FetchCount                  count of completed fetches, wraps at 2^32
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] NextPC,
    input  logic        PCUpdate,
    output logic [63:0] CurrentPC,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        Misaligned,
    output logic        FetchTimeout,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic        req, req_nxt;
    logic [31:0] instr, instr_nxt;
    logic        ivalid, ivalid_nxt;
    logic        mis, mis_nxt;
    logic        tmo, tmo_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [15:0] wcnt, wcnt_nxt;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req    <= 1'b0;
            instr  <= 32'h0;
            ivalid <= 1'b0;
            mis    <= 1'b0;
            tmo    <= 1'b0;
            cnt    <= 32'h0;
            wcnt   <= 16'h0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req    <= req_nxt;
            instr  <= instr_nxt;
            ivalid <= ivalid_nxt;
            mis    <= mis_nxt;
            tmo    <= tmo_nxt;
            cnt    <= cnt_nxt;
            wcnt   <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        req_nxt    = req;
        instr_nxt  = instr;
        ivalid_nxt = ivalid;
        mis_nxt    = mis;
        tmo_nxt    = tmo;
        cnt_nxt    = cnt;
        wcnt_nxt   = wcnt;
        case (state)
            FETCH: begin
                // req is low here only on the first cycle after reset. An ack is
                // accepted only once the request is actually visible on the bus.
                if (!req) begin
                    req_nxt = 1'b1;
                end else if (IMemAck) begin
                    instr_nxt  = IMemRdData;
                    ivalid_nxt = 1'b1;
                    req_nxt    = 1'b0;
                    cnt_nxt    = cnt + 32'd1;
                    wcnt_nxt   = 16'h0;
                    state_nxt  = VALID;
                end else begin
                    // Saturate at the limit; the flag stays set once raised.
                    if (wcnt != TMO_LIM) begin
                        wcnt_nxt = wcnt + 16'd1;
                    end
                    if (wcnt_nxt == TMO_LIM) begin
                        tmo_nxt = 1'b1;
                    end
                end
            end
            VALID: begin
                if (PCUpdate) begin
                    ivalid_nxt = 1'b0;
                    if (NextPC[1:0] == 2'b00) begin
                        pc_nxt    = NextPC;
                        req_nxt   = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        mis_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                req_nxt    = 1'b0;
                ivalid_nxt = 1'b0;
            end
            default: begin
                state_nxt = HALT;
                req_nxt   = 1'b0;
            end
        endcase
    end

    assign CurrentPC    = pc;
    assign IMemAddr     = pc;
    assign IMemReq      = req;
    assign Instruction  = instr;
    assign InstrValid   = ivalid;
    assign Misaligned   = mis;
    assign FetchTimeout = tmo;
    assign FetchCount   = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit (RESET_PC = 0, TIMEOUT = 4).
// A reference model advances at every clock edge, and its outputs are compared with the DUT 1 ns later.
// The directed sequences below also check hand-computed literal values.
module tb_pc_fetch_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] NextPC;
    logic        PCUpdate;
    logic [63:0] CurrentPC;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Misaligned;
    logic        FetchTimeout;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(TO)) dut (
        .CLK(CLK), .resetl(resetl), .NextPC(NextPC), .PCUpdate(PCUpdate),
        .CurrentPC(CurrentPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemRdData(IMemRdData), .Instruction(Instruction),
        .InstrValid(InstrValid), .Misaligned(Misaligned),
        .FetchTimeout(FetchTimeout), .FetchCount(FetchCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. m_fetching and m_halted describe the phase of the fetch unit.
    logic [63:0] m_pc    = 64'h0;
    logic        m_req   = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;
    logic        m_to    = 1'b0;
    logic [31:0] m_cnt   = 32'h0;
    int          m_wait  = 0;
    bit          m_fetching = 1'b1;
    bit          m_halted   = 1'b0;

    always @(posedge CLK) begin
        if (!resetl) begin
            m_pc = 64'h0; m_req = 0; m_instr = 0; m_valid = 0; m_mis = 0;
            m_to = 0; m_cnt = 0; m_wait = 0; m_fetching = 1; m_halted = 0;
        end else if (m_halted) begin
            // Nothing changes until reset.
        end else if (m_fetching) begin
            if (!m_req) begin
                m_req = 1;
            end else if (IMemAck) begin
                m_instr = IMemRdData; m_valid = 1; m_req = 0;
                m_cnt = m_cnt + 1; m_wait = 0; m_fetching = 0;
            end else begin
                if (m_wait < TO) m_wait++;
                if (m_wait >= TO) m_to = 1;
            end
        end else if (PCUpdate) begin
            m_valid = 0;
            if (NextPC[1:0] == 2'b00) begin
                m_pc = NextPC; m_req = 1; m_fetching = 1;
            end else begin
                m_mis = 1; m_halted = 1;
            end
        end
        #1;
        chk("cmp_pc", CurrentPC, m_pc);
        chk("cmp_addr", IMemAddr, m_pc);
        chk("cmp_req", IMemReq, m_req);
        chk("cmp_instr", Instruction, m_instr);
        chk("cmp_valid", InstrValid, m_valid);
        chk("cmp_misaligned", Misaligned, m_mis);
        chk("cmp_timeout", FetchTimeout, m_to);
        chk("cmp_count", FetchCount, m_cnt);
    end

    task automatic wait_req();
        int n = 0;
        while (IMemReq !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (IMemReq !== 1'b1) begin
            chk("wait_req_timeout", IMemReq, 1);
        end
    endtask

    // Hold off the ack for 'delay' cycles, then ack for one cycle.
    task automatic fetch(input logic [31:0] d, input int delay);
        wait_req();
        repeat (delay) @(negedge CLK);
        IMemAck = 1; IMemRdData = d;
        @(negedge CLK);
        IMemAck = 0; IMemRdData = 32'h0;
    endtask

    task automatic retire(input logic [63:0] n);
        PCUpdate = 1; NextPC = n;
        @(negedge CLK);
        PCUpdate = 0; NextPC = 64'h0;
    endtask

    initial begin
        resetl = 0; NextPC = 0; PCUpdate = 0; IMemAck = 0; IMemRdData = 0;
        repeat (3) @(negedge CLK);
        chk("rst_pc", CurrentPC, 64'h0);
        chk("rst_req", IMemReq, 0);
        chk("rst_count", FetchCount, 0);
        chk("rst_valid", InstrValid, 0);
        resetl = 1;
        @(negedge CLK);
        chk("req_rise", IMemReq, 1);

        // First fetch, with the ack on the second request cycle.
        fetch(32'h8B020020, 1);
        chk("first_instr", Instruction, 32'h8B020020);
        chk("first_valid", InstrValid, 1);
        chk("first_count", FetchCount, 1);
        chk("first_addr", IMemAddr, 64'h0);

        // Sequential flow up to PC 0x10.
        for (int a = 4; a <= 16; a += 4) begin
            retire(64'(a));
            fetch(32'hA0000000 | 32'(a), 0);
        end
        chk("seq_count", FetchCount, 5);
        chk("seq_pc", CurrentPC, 64'h10);
        retire(64'h14);
        chk("upd_pc", CurrentPC, 64'h14);
        chk("upd_valid", InstrValid, 0);
        chk("upd_req", IMemReq, 1);
        fetch(32'hA0000014, 2);
        chk("seq_valid", InstrValid, 1);
        chk("seq_count2", FetchCount, 6);

        // A stray ack in VALID changes nothing.
        IMemAck = 1; IMemRdData = 32'hDEADBEEF;
        @(negedge CLK);
        IMemAck = 0; IMemRdData = 0;
        @(negedge CLK);
        chk("stray_instr", Instruction, 32'hA0000014);
        chk("stray_count", FetchCount, 6);

        // Branch to 0x40 with a PCUpdate on the same cycle as the ack; the PCUpdate is dropped.
        retire(64'h40);
        wait_req();
        IMemAck = 1; IMemRdData = 32'hA0000040; PCUpdate = 1; NextPC = 64'h100;
        @(negedge CLK);
        IMemAck = 0; IMemRdData = 0; PCUpdate = 0; NextPC = 0;
        chk("simul_pc", CurrentPC, 64'h40);
        chk("simul_instr", Instruction, 32'hA0000040);
        chk("simul_count", FetchCount, 7);

        // A misaligned target halts the unit.
        retire(64'h46);
        chk("mis_flag", Misaligned, 1);
        chk("mis_pc", CurrentPC, 64'h40);
        chk("mis_valid", InstrValid, 0);
        for (int i = 0; i < 20; i++) begin
            IMemAck = i[0]; PCUpdate = ~i[0]; NextPC = 64'h200; IMemRdData = 32'h12345678;
            @(negedge CLK);
            chk("halt_req", IMemReq, 0);
        end
        IMemAck = 0; PCUpdate = 0; NextPC = 0; IMemRdData = 0;
        chk("halt_pc", CurrentPC, 64'h40);
        chk("halt_count", FetchCount, 7);

        // Timeout: hold off the ack for 6 cycles; the flag rises after 4.
        resetl = 0;
        @(negedge CLK);
        resetl = 1;
        @(negedge CLK);
        chk("tmo_req_rise", IMemReq, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("tmo_flag", FetchTimeout, (i >= 3));
            chk("tmo_req_held", IMemReq, 1);
        end
        IMemAck = 1; IMemRdData = 32'hC0FFEE00;
        @(negedge CLK);
        IMemAck = 0; IMemRdData = 0;
        chk("tmo_instr", Instruction, 32'hC0FFEE00);
        chk("tmo_sticky", FetchTimeout, 1);
        chk("tmo_count", FetchCount, 1);

        // Asynchronous reset during a fetch at 0x80.
        retire(64'h80);
        chk("pre_arst_pc", CurrentPC, 64'h80);
        chk("pre_arst_req", IMemReq, 1);
        #2 resetl = 0;
        #1;
        chk("arst_req", IMemReq, 0);
        chk("arst_valid", InstrValid, 0);
        chk("arst_count", FetchCount, 0);
        chk("arst_pc", CurrentPC, 64'h0);
        chk("arst_timeout", FetchTimeout, 0);
        @(negedge CLK);
        resetl = 1;
        wait_req();
        chk("post_arst_addr", IMemAddr, 64'h0);
        fetch(32'h0BADF00D, 0);
        chk("post_arst_count", FetchCount, 1);
        chk("post_arst_instr", Instruction, 32'h0BADF00D);

        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
